serial_sub8: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 17 +
 rtl/serial_sub8_fullsub.sv | 13 +
 rtl/serial_sub8.sv | 129 ++++++++++++
 tb/tb_serial_sub8.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_sub8_fullsub.sv
// One-bit full-subtractor cell: d = a - b - bin with borrow out.
module fullsub (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub8.sv
// Bit-serial subtractor, diff = a - b, LSB first through one fullsub cell.
// Result is zeroed on signed overflow; bout/flow report borrow and overflow.
//
// state | meaning
// IDLE  | waiting for start, in_ready high
// RUN   | one operand bit per clock, counter tracks bit index
// DONE  | result held with out_valid until out_ready
module serial_sub8
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             in_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             flow,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_sh_q, a_sh_d;
   logic [WIDTH-1:0]  b_sh_q, b_sh_d;
   logic [WIDTH-1:0]  res_q, res_d;
   logic              br_q, br_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0]  diff_q, diff_d;
   logic              bout_q, bout_d;
   logic              flow_q, flow_d;
   logic              out_valid_q, out_valid_d;

   logic              d_bit;
   logic              bo_bit;

   fullsub u_fullsub (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .bin  (br_q),
      .d    (d_bit),
      .bout (bo_bit)
   );

   always_comb begin
      state_d     = state_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      res_d       = res_q;
      br_d        = br_q;
      cnt_d       = cnt_q;
      diff_d      = diff_q;
      bout_d      = bout_q;
      flow_d      = flow_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               br_d    = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            res_d  = {d_bit, res_q[WIDTH-1:1]};
            br_d   = bo_bit;
            cnt_d  = cnt_q + CNT_W'(1);
            // On the MSB bit br_q is the borrow into the MSB.
            if (cnt_q == LAST_BIT) begin
               flow_d      = br_q ^ bo_bit;
               bout_d      = bo_bit;
               diff_d      = (br_q ^ bo_bit) ? '0 : {d_bit, res_q[WIDTH-1:1]};
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         res_q       <= '0;
         br_q        <= 1'b0;
         cnt_q       <= '0;
         diff_q      <= '0;
         bout_q      <= 1'b0;
         flow_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         res_q       <= res_d;
         br_q        <= br_d;
         cnt_q       <= cnt_d;
         diff_q      <= diff_d;
         bout_q      <= bout_d;
         flow_q      <= flow_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign diff      = diff_q;
   assign bout      = bout_q;
   assign flow      = flow_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_serial_sub8.sv
// Directed self-checking bench for serial_sub8 (WIDTH = 8).
module tb_serial_sub8;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       in_ready;
   logic [7:0] diff;
   logic       bout;
   logic       flow;
   logic       out_valid;
   logic       out_ready;

   int checks = 0;
   int errors = 0;

   serial_sub8 #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .in_ready  (in_ready),
      .diff      (diff),
      .bout      (bout),
      .flow      (flow),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] e_diff, input logic e_bout, input logic e_flow);
      @(negedge clk);
      check({tag, " in_ready before"}, 32'(in_ready), 32'd1);
      a = va;
      b = vb;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a = ~va;
      b = va ^ vb;
      check({tag, " in_ready run"}, 32'(in_ready), 32'd0);
      repeat (7) @(posedge clk);
      @(negedge clk);
      check({tag, " out_valid early"}, 32'(out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check({tag, " out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " diff"}, 32'(diff), 32'(e_diff));
      check({tag, " bout"}, 32'(bout), 32'(e_bout));
      check({tag, " flow"}, 32'(flow), 32'(e_flow));
   endtask

   task automatic drain(input string tag, input logic [7:0] e_diff);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
      check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
      check({tag, " diff kept"}, 32'(diff), 32'(e_diff));
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a = 8'h00;
      b = 8'h00;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst diff", 32'(diff), 32'd0);
      check("rst bout", 32'(bout), 32'd0);
      check("rst flow", 32'(flow), 32'd0);
      rst_n = 1'b1;

      do_op("5-3", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
      drain("5-3", 8'h02);

      do_op("3-5", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
      drain("3-5", 8'hFE);

      do_op("80-01", 8'h80, 8'h01, 8'h00, 1'b0, 1'b1);
      drain("80-01", 8'h00);

      do_op("7F-FF", 8'h7F, 8'hFF, 8'h00, 1'b1, 1'b1);
      drain("7F-FF", 8'h00);

      do_op("A5-5A", 8'hA5, 8'h5A, 8'h00, 1'b0, 1'b1);
      drain("A5-5A", 8'h00);

      do_op("C8-32", 8'hC8, 8'h32, 8'h96, 1'b0, 1'b0);
      drain("C8-32", 8'h96);

      // Hold in DONE with start pulsing; start must be ignored.
      do_op("hold", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         start = 1'b1;
         a = 8'h40 + 8'(i);
         b = 8'h01;
         @(posedge clk);
         @(negedge clk);
         check("hold diff", 32'(diff), 32'hFE);
         check("hold bout", 32'(bout), 32'd1);
         check("hold flow", 32'(flow), 32'd0);
         check("hold out_valid", 32'(out_valid), 32'd1);
         check("hold in_ready", 32'(in_ready), 32'd0);
      end
      start = 1'b0;
      drain("hold", 8'hFE);
      @(posedge clk);
      @(negedge clk);
      check("hold no accept", 32'(in_ready), 32'd1);
      check("hold no valid", 32'(out_valid), 32'd0);

      // Reset during bit 3 of RUN.
      a = 8'h55;
      b = 8'h11;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("midrun in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check("midrst in_ready", 32'(in_ready), 32'd1);
      check("midrst out_valid", 32'(out_valid), 32'd0);
      check("midrst diff", 32'(diff), 32'd0);
      check("midrst bout", 32'(bout), 32'd0);
      check("midrst flow", 32'(flow), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      do_op("10-01", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);
      drain("10-01", 8'h0F);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
